aes_dec_sched: RTL and testbench

AES_DEC_SCHED -- requirements
Module: aes_dec_sched

---
 rtl/aes_sched_pkg.sv | 23 ++
 rtl/aes_rr_arb.sv | 31 +++
 rtl/aes_dec_sched.sv | 150 +++++++++++++++
 tb/tb_aes_dec_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_sched_pkg
// Description : Shared types and sizes for the two-requester inverse-AES
//               scheduler: FSM state encoding, requester count, block width
//               and WAIT timer width.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_sched_pkg;

  localparam int NUM_REQ = 2;
  localparam int BLK_W   = 128;
  localparam int TMR_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage : aes_sched_pkg
`default_nettype wire

// File: rtl/aes_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : aes_rr_arb
// Description : Two-input combinational arbiter. A single active request is
//               granted directly; when both are active, prio selects the
//               winner (0 -> requester 0, 1 -> requester 1).
// Ports       : valid - request bits, one per requester
//               prio  - tie-break selector
//               grant - one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rr_arb
  import aes_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic               prio,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

endmodule : aes_rr_arb
`default_nettype wire

// File: rtl/aes_dec_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_dec_sched
// Description : Shares one inverse-AES core between two requesters. Accepts
//               one request at a time, pulses the core start, waits for the
//               result with a timeout, and returns plaintext (or an error)
//               to the requester that owns the operation.
// Ports       : clk, reset                 - clock, sync active-high reset
//               req_valid/ready/data/key   - per-requester request channel
//               core_valid/data/key        - start pulse and operands to core
//               core_res_valid/res_data    - result from core
//               rsp_valid/ready            - per-requester response channel
//               rsp_data, rsp_err          - shared response payload
// Revision    : 1.0 - initial release
// ============================================================================
module aes_dec_sched
  import aes_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][BLK_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0][BLK_W-1:0]  req_key,
  output logic                           core_valid,
  output logic [BLK_W-1:0]               core_data,
  output logic [BLK_W-1:0]               core_key,
  input  logic                           core_res_valid,
  input  logic [BLK_W-1:0]               core_res_data,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [BLK_W-1:0]               rsp_data,
  output logic                           rsp_err
);

  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_prio;
  logic               r_owner;
  logic [TMR_W-1:0]   r_timer;
  logic [BLK_W-1:0]   r_data;
  logic [BLK_W-1:0]   r_key;
  logic [BLK_W-1:0]   r_rsp_data;
  logic               r_rsp_err;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_accept;
  logic               w_timeout;
  logic               w_rsp_done;
  logic               w_gnt_idx;

  aes_rr_arb u_arb (
    .valid (req_valid),
    .prio  (r_prio),
    .grant (w_grant)
  );

  // Grant is one-hot, so bit 1 alone identifies the winning requester.
  assign w_gnt_idx  = w_grant[1];
  assign w_accept   = (r_state == IDLE) && (|w_grant);
  assign w_timeout  = (r_state == WAIT) && (r_timer == C_TMR_LAST);
  assign w_rsp_done = (r_state == RESP) && rsp_ready[r_owner];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    if (core_res_valid || w_timeout) w_state_nxt = RESP;
      RESP:    if (w_rsp_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = '0;
    core_valid = 1'b0;
    rsp_valid  = '0;
    case (r_state)
      IDLE:    req_ready  = w_grant;
      ISSUE:   core_valid = 1'b1;
      RESP:    rsp_valid  = r_owner ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // Datapath: operand capture, WAIT timer, response payload and priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio     <= 1'b0;
      r_owner    <= 1'b0;
      r_timer    <= '0;
      r_data     <= '0;
      r_key      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data  <= req_data[w_gnt_idx];
            r_key   <= req_key[w_gnt_idx];
            r_owner <= w_gnt_idx;
          end
        end
        ISSUE: begin
          r_timer <= '0;
        end
        WAIT: begin
          // A result arriving in the final timer cycle beats the timeout.
          if (core_res_valid) begin
            r_rsp_data <= core_res_data;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        RESP: begin
          if (w_rsp_done) r_prio <= ~r_owner;
        end
        default: ;
      endcase
    end
  end

  assign core_data = r_data;
  assign core_key  = r_key;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule : aes_dec_sched
`default_nettype wire

// File: tb/tb_aes_dec_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_dec_sched
// Description : Directed self-checking bench for aes_dec_sched. The bench
//               plays the core itself, returning a chosen plaintext after a
//               chosen number of WAIT cycles (or never).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_dec_sched;

  localparam int TMO = 8;

  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0][127:0]    req_data;
  logic [1:0][127:0]    req_key;
  logic                 core_valid;
  logic [127:0]         core_data;
  logic [127:0]         core_key;
  logic                 core_res_valid;
  logic [127:0]         core_res_data;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready;
  logic [127:0]         rsp_data;
  logic                 rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  aes_dec_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_key        (req_key),
    .core_valid     (core_valid),
    .core_data      (core_data),
    .core_key       (core_key),
    .core_res_valid (core_res_valid),
    .core_res_data  (core_res_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'(2'b00));
    chk("rst_core_valid", 128'(core_valid), 128'(1'b0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(2'b00));
    chk("rst_core_data", core_data, 128'h0);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_rsp_data", rsp_data, 128'h0);
    chk("rst_rsp_err", 128'(rsp_err), 128'(1'b0));
    reset = 1'b0;
  endtask

  // One full operation. res_at: WAIT cycle index in which the core result
  // is presented (-1 = never). hold: cycles of response backpressure during
  // which the other requester is valid, non-owner rsp_ready is high and
  // junk core results are presented.
  task automatic run_op(input int who, input logic [1:0] vmask,
                        input logic [127:0] ct, input logic [127:0] key,
                        input int res_at, input logic [127:0] pt,
                        input logic [127:0] exp_d, input logic exp_e,
                        input int hold);
    logic [1:0] own;
    int         n;
    int         exp_n;
    own   = (who == 1) ? 2'b10 : 2'b01;
    exp_n = (res_at < 0) ? TMO : res_at + 1;

    @(negedge clk);
    req_valid       = vmask;
    req_data[who]   = ct;
    req_key[who]    = key;
    req_data[1-who] = ~ct;
    req_key[1-who]  = ~key;
    #1;
    chk("grant", 128'(req_ready), 128'(own));

    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("core_valid_issue", 128'(core_valid), 128'(1'b1));
    chk("core_data", core_data, ct);
    chk("core_key", core_key, key);

    @(posedge clk);
    #1;
    chk("core_valid_wait", 128'(core_valid), 128'(1'b0));

    n = 0;
    for (int k = 0; k < 20; k++) begin
      core_res_valid = (k == res_at);
      core_res_data  = (k == res_at) ? pt : {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
      core_res_valid = 1'b0;
      n++;
      if (rsp_valid != 2'b00) break;
    end
    chk("rsp_valid", 128'(rsp_valid), 128'(own));
    chk("wait_len", 128'(n), 128'(exp_n));
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", 128'(rsp_err), 128'(exp_e));
    chk("core_data_hold", core_data, ct);

    for (int h = 0; h < hold; h++) begin
      req_valid      = 2'b11;
      rsp_ready      = ~own;
      core_res_valid = 1'b1;
      core_res_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
      chk("bp_rsp_data", rsp_data, exp_d);
      chk("bp_rsp_err", 128'(rsp_err), 128'(exp_e));
      chk("bp_rsp_valid", 128'(rsp_valid), 128'(own));
      chk("bp_req_ready", 128'(req_ready), 128'(2'b00));
      chk("bp_core_valid", 128'(core_valid), 128'(1'b0));
    end
    req_valid      = 2'b00;
    core_res_valid = 1'b0;
    rsp_ready      = own;
    @(posedge clk);
    #1;
    rsp_ready = 2'b00;
    chk("rsp_done", 128'(rsp_valid), 128'(2'b00));
    chk("idle_core_valid", 128'(core_valid), 128'(1'b0));
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 2'b00;
    req_data       = '0;
    req_key        = '0;
    core_res_valid = 1'b0;
    core_res_data  = '0;
    rsp_ready      = 2'b00;

    // Reset state
    do_reset();

    // Single request with 20 cycles of response backpressure
    run_op(0, 2'b01, C_CT, C_KEY, 3, C_PT, C_PT, 1'b0, 20);

    // Contention after reset: 0,1,0,1
    do_reset();
    run_op(0, 2'b11, C_CT, C_KEY, 0, C_PT, C_PT, 1'b0, 1);
    run_op(1, 2'b11, 128'h1111, 128'h2222, 2, 128'hdead_beef, 128'hdead_beef, 1'b0, 0);
    run_op(0, 2'b11, 128'h3333, 128'h4444, 5, 128'hcafe, 128'hcafe, 1'b0, 0);
    run_op(1, 2'b11, 128'h5555, 128'h6666, 1, 128'hf00d, 128'hf00d, 1'b0, 0);

    // Timeout with no core result, then late results ignored in RESP
    run_op(1, 2'b10, C_CT, C_KEY, -1, C_PT, 128'h0, 1'b1, 4);

    // Result arrives in the same cycle as the timeout
    run_op(0, 2'b01, C_CT, C_KEY, TMO - 1, C_PT, C_PT, 1'b0, 0);

    // Reset while in WAIT, then stale result must not respond
    @(negedge clk);
    req_valid   = 2'b01;
    req_data[0] = C_CT;
    req_key[0]  = C_KEY;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstw_rsp_valid", 128'(rsp_valid), 128'(2'b00));
    chk("rstw_core_valid", 128'(core_valid), 128'(1'b0));
    chk("rstw_core_data", core_data, 128'h0);
    core_res_valid = 1'b1;
    core_res_data  = C_PT;
    @(posedge clk);
    #1;
    core_res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stale_rsp_valid", 128'(rsp_valid), 128'(2'b00));
      chk("stale_rsp_data", rsp_data, 128'h0);
      @(posedge clk);
      #1;
    end
    run_op(0, 2'b11, C_CT, C_KEY, 4, C_PT, C_PT, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_aes_dec_sched
`default_nettype wire
